apb_fifo_completer: RTL
=======================

Name: apb_fifo_completer

Overview:
- APB completer that terminates the bridge's APB master side in the subsystem.
- Exposes a transmit FIFO through a small register map: APB writes push words, and a downstream valid/ready stream drains them.
- Also provides status, control and a threshold interrupt.
- Serves as the far end of the bridge's buffered APB path and as a bench target for bridge verification.

Parameters:
- ADDR_WIDTH, 12: paddr_i width; only bits [3:2] are decoded, bits [1:0] are ignored.
- DEPTH, 8: FIFO entries, power of two, 2..256.
- THRESH_RST, 4: reset value of the THRESH register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  ADDR_WIDTH  APB address
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- data_o  out  32  stream data (FIFO head)
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- irq_o  out  1  level interrupt: fill count >= THRESH

Behaviour:
- Single clock clk_i; reset is asynchronous, active-low (rst_ni).
- Reset state:
  - FIFO empty, pointers 0.
  - CTRL.en = 0, THRESH = THRESH_RST.
  - FSM in IDLE.
  - prdata_o, pready_o, pslverr_o, valid_o, irq_o, data_o = 0.
- FSM states: IDLE, SETUP, ACCESS, WAIT.
  - IDLE → SETUP on psel_i & !penable_i.
  - SETUP → ACCESS next cycle. ACCESS requires psel_i & penable_i; otherwise the FSM returns to IDLE and performs no register effect.
  - ACCESS: pready_o = 1 combinationally in the same cycle (zero wait states), unless the stall case applies → WAIT.
  - After a completed transfer: → SETUP if psel_i & !penable_i, else → IDLE.
  - penable_i seen in IDLE (no prior setup): complete immediately with pslverr_o = 1 and no effect.
- prdata_o and pslverr_o are meaningful only while pready_o = 1 and are driven 0 otherwise.
- Register map (offset = paddr_i[3:2] × 4):
  - 0x0 DATA
    - Write pushes pwdata_i.
    - Read returns 0.
  - 0x4 STATUS (RO)
    - [0] empty, [1] full, [2] irq.
    - [31:16] fill count, zero-extended, width $clog2(DEPTH)+1.
    - Write → pslverr_o = 1, no effect.
  - 0x8 CTRL
    - [0] flush: write-1, self-clearing, reads 0.
    - [1] en: read/write.
  - 0xC THRESH
    - [8:0] read/write; upper bits read 0.
    - THRESH = 0 → irq_o is constantly 1.
- Stream side:
  - valid_o = en & !empty; data_o = head entry.
  - A pop occurs on valid_o & ready_i at the clock edge.
  - data_o is held stable while valid_o & !ready_i.
- FIFO:
  - Read/write pointers wrap modulo DEPTH.
  - Count = 0..DEPTH; full when count == DEPTH.
  - Push and pop in the same cycle: count unchanged; both take effect.
  - A DATA write while full is treated as full even if a pop occurs in the same cycle; see Optional Feature.
- Flush:
  - Takes effect at the edge ending the CTRL write access.
  - Clears pointers and count.
  - A same-cycle pop is ignored.
  - valid_o = 0 on the next cycle.
- irq_o is registered: it reflects count and THRESH after each edge.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and FIFO contents are lost. The requester must restart the transfer.

Optional Feature:
- Macro APB_FIFO_STALL_EN.
- Defined: a DATA write while full enters WAIT with pready_o = 0.
  - The write completes (push, pready_o = 1, pslverr_o = 0) in the first cycle in which count < DEPTH as seen at the start of that cycle.
  - No timeout.
- Undefined: a DATA write while full completes in ACCESS with pslverr_o = 1 and the data is dropped; the WAIT state is not built.

Test Plan:
- Reset, then read STATUS → 0x00000001; read THRESH → 4; irq_o = 0; valid_o = 0.
- Write CTRL = 0x2, write DATA 0xA5A5_0001..0xA5A5_0003, ready_i = 1 → data_o sequence 0xA5A5_0001, _0002, _0003 in order, one per cycle; then empty.
- en = 0, push 8 words → STATUS = 0x0008_0006 (count 8, full, irq).
  - 9th write without macro → pslverr_o = 1, count stays 8.
  - 9th write with macro → pready_o = 0 until ready_i pops one word; then the write completes and the last word read out is the 9th.
- Hold ready_i = 0 with valid_o = 1 for 5 cycles → data_o stable; pop and push in the same cycle at count 3 → count stays 3.
- Fill 5 words, write CTRL = 0x3 → next cycle STATUS.empty = 1, irq_o = 0, valid_o = 0, en remains 1.
- Write STATUS, and apply penable_i without a setup phase → pslverr_o = 1, registers unchanged; assert rst_ni low during WAIT → FSM idle, pready_o = 0, FIFO empty.

Source files
------------

// File: rtl/apb_fifo_completer.sv
// APB completer fronting a transmit FIFO that drains through a valid/ready stream.
// Optional: define APB_FIFO_STALL_EN to stall DATA writes while full instead of erroring them.
module apb_fifo_completer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int THRESH_RST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [31:0]           data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  irq_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // SETUP means a setup phase was captured, so the current cycle is the access phase.
`ifdef APB_FIFO_STALL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_WAIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETUP = 2'd1} state_t;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [8:0]    r_thresh;
    logic [8:0]    w_thresh_nxt;
    logic          r_en;
    logic          r_irq;
    logic          w_setup;
    logic          w_acc;
    logic          w_full;
    logic          w_empty;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic          w_thresh_wr;
    logic          w_pready;
    logic          w_pslverr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_setup  = psel_i & ~penable_i;
    assign w_acc    = psel_i & penable_i;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == {CW{1'b0}});
    assign w_valid  = r_en & ~w_empty;
    assign w_flush  = w_ctrl_wr & pwdata_i[0];
    // Flush wins over a pop landing on the same edge.
    assign w_pop    = w_valid & ready_i & ~w_flush;
    assign w_status = {16'(r_count), 13'd0, r_irq, w_full, w_empty};
    assign w_unused = ^{paddr_i, pwdata_i};

    // APB phase tracking, register decode and response generation.
    always_comb begin
        w_next      = r_state;
        w_pready    = 1'b0;
        w_pslverr   = 1'b0;
        w_rdata     = 32'd0;
        w_push      = 1'b0;
        w_ctrl_wr   = 1'b0;
        w_thresh_wr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_pready  = 1'b1;
                    w_pslverr = 1'b1;
                    w_next    = ST_IDLE;
                end else if (w_setup) begin
                    w_next = ST_SETUP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_acc) begin
                    w_pready = 1'b1;
                    w_next   = w_setup ? ST_SETUP : ST_IDLE;
                    case (paddr_i[3:2])
                        2'd0: begin
                            if (pwrite_i) begin
                                if (w_full) begin
`ifdef APB_FIFO_STALL_EN
                                    w_pready = 1'b0;
                                    w_next   = ST_WAIT;
`else
                                    w_pslverr = 1'b1;
`endif
                                end else begin
                                    w_push = 1'b1;
                                end
                            end else begin
                                w_rdata = 32'd0;
                            end
                        end
                        2'd1: begin
                            if (pwrite_i) begin
                                w_pslverr = 1'b1;
                            end else begin
                                w_rdata = w_status;
                            end
                        end
                        2'd2: begin
                            if (pwrite_i) begin
                                w_ctrl_wr = 1'b1;
                            end else begin
                                w_rdata = {30'd0, r_en, 1'b0};
                            end
                        end
                        default: begin
                            if (pwrite_i) begin
                                w_thresh_wr = 1'b1;
                            end else begin
                                w_rdata = {23'd0, r_thresh};
                            end
                        end
                    endcase
                end else begin
                    w_next = ST_IDLE;
                end
            end
`ifdef APB_FIFO_STALL_EN
            ST_WAIT: begin
                if (!w_full) begin
                    w_pready = 1'b1;
                    w_push   = 1'b1;
                    w_next   = w_setup ? ST_SETUP : ST_IDLE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Next fill level and threshold, used for the registered interrupt.
    always_comb begin
        w_count_nxt  = r_count;
        w_thresh_nxt = w_thresh_wr ? pwdata_i[8:0] : r_thresh;
        if (w_flush) begin
            w_count_nxt = {CW{1'b0}};
        end else if (w_push & ~w_pop) begin
            w_count_nxt = r_count + CW'(1'b1);
        end else if (~w_push & w_pop) begin
            w_count_nxt = r_count - CW'(1'b1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FSM state, control registers and interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_en     <= 1'b0;
            r_thresh <= 9'(THRESH_RST);
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_thresh <= w_thresh_nxt;
            r_irq    <= (9'(w_count_nxt) >= w_thresh_nxt);
            if (w_ctrl_wr) begin
                r_en <= pwdata_i[1];
            end
        end
    end

    // FIFO storage, pointers and fill count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_count <= w_count_nxt;
            if (w_flush) begin
                r_wr_ptr <= {PW{1'b0}};
                r_rd_ptr <= {PW{1'b0}};
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= pwdata_i;
                    r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1'b1);
                end
            end
        end
    end

    assign prdata_o  = w_rdata;
    assign pready_o  = w_pready;
    assign pslverr_o = w_pslverr;
    assign valid_o   = w_valid;
    assign data_o    = r_mem[r_rd_ptr];
    assign irq_o     = r_irq;

endmodule
